// File: rtl/add64_seq_pkg.sv
// ---------------------------------------------------------------------------
// add64_seq_pkg
// Shared definitions for the multi-cycle 64-bit adder: datapath word width
// and the controller state encoding.
// Ports: none (package).
// ---------------------------------------------------------------------------
package add64_seq_pkg;

  localparam int WORD_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of slice cycles a full word takes for a given slice width.
  function automatic int slice_count(input int slice_w);
    return WORD_W / slice_w;
  endfunction

endpackage

// File: rtl/add64_seq_add_slice.sv
// ---------------------------------------------------------------------------
// add_slice
// Purely combinational W-bit ripple-carry adder slice, built from single-bit
// full adders so no behavioural '+' is involved.
// Ports:
//   a, b  : W-bit operand slices
//   cin   : carry in
//   s     : W-bit slice sum
//   cout  : carry out of the slice MSB
// ---------------------------------------------------------------------------
module add_slice #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W:0] c;

  assign c[0] = cin;

  // Carry ripples bit by bit from the slice LSB to its MSB.
  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[W];

endmodule

// File: rtl/add64_seq.sv
// ---------------------------------------------------------------------------
// add64_seq
// Sequential 64-bit adder that processes one SLICE_W-bit slice per clock,
// LSB slice first, with the inter-slice carry held in a register. Operands
// are taken with a valid/ready handshake; the result and flags are held
// until the consumer handshakes them away.
//
// Parameter:
//   SLICE_W   : slice width per cycle (8, 16, 32 or 64)
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   in_valid  : operand pair offered
//   in_ready  : high only in IDLE
//   a, b      : signed 64-bit operands
//   out_valid : high only in DONE, result held
//   out_ready : consumer takes result
//   sum       : a+b modulo 2^64
//   cf        : unsigned carry out of bit 63
//   of        : signed overflow
//   zf        : zero flag
// Configuration:
//   ADD64_SEQ_ZF_EN defined   -> zf = (sum == 0), registered with sum
//   ADD64_SEQ_ZF_EN undefined -> zf tied to 0
// ---------------------------------------------------------------------------
module add64_seq
  import add64_seq_pkg::*;
#(
  parameter int SLICE_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] sum,
  output logic        cf,
  output logic        of,
  output logic        zf
);

  localparam int NSLICE = slice_count(SLICE_W);
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  state_t state, state_next;

  logic [WORD_W-1:0]  a_q, b_q, acc_q;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;

  logic [SLICE_W-1:0] slice_a, slice_b, slice_s;
  logic               slice_cout;
  logic [WORD_W-1:0]  full_sum;
  logic               last_slice;
  logic               full_of;

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign last_slice = (idx_q == LAST_IDX);

  assign slice_a = a_q[int'(idx_q) * SLICE_W +: SLICE_W];
  assign slice_b = b_q[int'(idx_q) * SLICE_W +: SLICE_W];

  add_slice #(.W(SLICE_W)) u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  // Partial result with the current slice merged in; on the last slice this
  // is the complete 64-bit sum.
  always_comb begin
    full_sum = acc_q;
    full_sum[int'(idx_q) * SLICE_W +: SLICE_W] = slice_s;
  end

  assign full_of = (a_q[WORD_W-1] == b_q[WORD_W-1]) &&
                   (full_sum[WORD_W-1] != a_q[WORD_W-1]);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. In IDLE in_ready is high, so in_valid alone is the
  // acceptance handshake; out_ready only matters in DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)   state_next = CALC;
      CALC:    if (last_slice) state_next = DONE;
      DONE:    if (out_ready)  state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Datapath: capture operands on acceptance, walk the slices in CALC, and
  // publish result and flags only on the final slice so they stay frozen
  // through IDLE/CALC of the following operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum     <= '0;
      cf      <= 1'b0;
      of      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            acc_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
          end
        end
        CALC: begin
          acc_q   <= full_sum;
          carry_q <= slice_cout;
          if (last_slice) begin
            idx_q <= '0;
            sum   <= full_sum;
            cf    <= slice_cout;
            of    <= full_of;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ADD64_SEQ_ZF_EN
  logic zf_q;

  // Zero flag registered alongside sum so it changes on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zf_q <= 1'b0;
    end else if (state == CALC && last_slice) begin
      zf_q <= (full_sum == '0);
    end
  end

  assign zf = zf_q;
`else
  assign zf = 1'b0;
`endif

endmodule

// File: doc/add64_seq.md
ADD64_SEQ -- requirements
Module: add64_seq

Interface
REQ-001 SHALL have parameter: SLICE_W, 16, adder slice width in bits per cycle; legal values 8, 16, 32, 64.
REQ-002 SHALL have port: clk  input  1  sole clock, rising-edge.
REQ-003 SHALL have port: rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 SHALL have port: in_valid  input  1  operand pair offered.
REQ-005 SHALL have port: in_ready  output  1  block can accept operands.
REQ-006 SHALL have port: a  input  64  signed augend.
REQ-007 SHALL have port: b  input  64  signed addend.
REQ-008 SHALL have port: out_valid  output  1  result held and valid.
REQ-009 SHALL have port: out_ready  input  1  consumer takes result.
REQ-010 SHALL have port: sum  output  64  a+b modulo 2^64.
REQ-011 SHALL have port: cf  output  1  unsigned carry out of bit 63.
REQ-012 SHALL have port: of  output  1  signed overflow.
REQ-013 SHALL have port: zf  output  1  zero flag, see Configuration.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE.
REQ-015 SHALL assert in_ready only in IDLE; out_valid only in DONE.
REQ-016 SHALL capture a, b on a clk edge with in_valid && in_ready; move IDLE->CALC; clear slice index and carry.
REQ-017 SHALL in CALC add one SLICE_W slice per cycle, LSB slice first, carry registered between slices.
REQ-018 SHALL move CALC->DONE after 64/SLICE_W slice cycles; out_valid rises exactly 64/SLICE_W cycles after the acceptance edge (4 at default).
REQ-019 SHALL compute cf = carry out of slice containing bit 63.
REQ-020 SHALL compute of = (a[63]==b[63]) && (sum[63]!=a[63]) from captured operands.
REQ-021 SHALL hold sum, cf, of, zf stable while out_valid && !out_ready.
REQ-022 SHALL move DONE->IDLE on out_valid && out_ready; next acceptance earliest the following edge (no same-cycle turnaround).
REQ-023 SHALL ignore in_valid and a/b changes outside IDLE.
REQ-024 SHALL ignore out_ready outside DONE.
REQ-025 SHALL leave sum/flags at last result value in IDLE and CALC (updated only on entry to DONE).

Reset
REQ-026 SHALL on rst_n low, asynchronously: state IDLE, in_ready 1 after release, out_valid 0, sum 0, cf 0, of 0, zf 0, slice index 0, carry 0.
REQ-027 SHALL abort any in-flight operation on reset mid-CALC or mid-DONE; no result emitted for it.

Configuration
REQ-028 SHALL use macro ADD64_SEQ_ZF_EN.
REQ-029 SHALL with ADD64_SEQ_ZF_EN defined drive zf = (sum == 0), registered with sum.
REQ-030 SHALL without ADD64_SEQ_ZF_EN keep port zf, tied constant 0, no zero-detect logic.

Structure
REQ-031 SHALL place state encoding typedef (IDLE/CALC/DONE) and WORD_W=64 constant in shared package add64_seq_pkg.
REQ-032 SHALL instantiate one combinational sub-module add_slice (SLICE_W-bit a, b, cin -> s, cout); no behavioural 64-bit '+'.

Verification
REQ-033 SHALL test: a=5, b=3 -> sum=8, cf=0, of=0, zf=0; out_valid exactly 4 cycles after accept.
REQ-034 SHALL test: a=0x0000_0000_0000_FFFF, b=1 -> sum=0x0000_0000_0001_0000 (cross-slice carry), cf=0, of=0.
REQ-035 SHALL test: a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> sum=0x8000_0000_0000_0000, of=1, cf=0.
REQ-036 SHALL test: a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> sum=0, cf=1, of=0, zf=1 (0 if ADD64_SEQ_ZF_EN undefined).
REQ-037 SHALL test: out_ready low 5 cycles in DONE -> outputs stable, in_ready 0, a/b changes ignored; handshake -> IDLE next edge.
REQ-038 SHALL test: rst_n pulsed low during CALC slice 2 -> out_valid 0, all outputs 0, next operands a=2, b=2 -> sum=4 after 4 cycles.
